// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and default parameters for seq_gen
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int DEF_N   = 4;
    localparam int DEF_GAP = 0;
    localparam int DEF_RW  = 4;

endpackage

// File: rtl/seq_gen_shreg.sv
// rtl/seq_gen_shreg.sv - N-bit load/shift register with bit counter and last-bit flag
module seq_gen_shreg #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic         shift,
    input  logic [N-1:0] load_data,
    output logic         tx_bit,
    output logic         last_bit
);

    localparam int CW = $clog2(N);

    logic [N-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;

    // On load the MSB leaves immediately, so only the remaining bits are stored
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (load) begin
            shreg_d   = {load_data[N-2:0], 1'b0};
            bit_cnt_d = '0;
        end else if (shift) begin
            shreg_d   = {shreg_q[N-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + CW'(1);
        end
    end

    // Register and counter state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Bit to put on the line at the coming edge: fresh word MSB on load, else stored MSB
    assign tx_bit   = load ? load_data[N-1] : shreg_q[N-1];
    assign last_bit = (bit_cnt_q == CW'(N-1));

endmodule

// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - MSB-first serial word transmitter with gap and optional repeats (SEQ_GEN_REPEAT_EN)
module seq_gen
    import seq_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int GAP = DEF_GAP
`ifdef SEQ_GEN_REPEAT_EN
    , parameter int RW = DEF_RW
`endif
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [N-1:0]  word_i,
`ifdef SEQ_GEN_REPEAT_EN
    input  logic [RW-1:0] repeat_i,
`endif
    output logic          xout,
    output logic          busy,
    output logic          done_o
);

    state_e       state_q, state_d;
    logic         xout_q, xout_d;
    logic         done_q, done_d;
    logic [N-1:0] hold_q, hold_d;
    logic [N-1:0] sh_data;
    logic         sh_load, sh_shift, sh_tx_bit, sh_last;
    logic         gap_last;
    logic         reps_left;

`ifdef SEQ_GEN_REPEAT_EN
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    assign reps_left = (rep_cnt_q != '0);
`else
    assign reps_left = 1'b0;
`endif

    seq_gen_shreg #(.N(N)) u_shreg (
        .clk       (clk),
        .rstn      (rstn),
        .load      (sh_load),
        .shift     (sh_shift),
        .load_data (sh_data),
        .tx_bit    (sh_tx_bit),
        .last_bit  (sh_last)
    );

    generate
        if (GAP > 0) begin : g_gap
            localparam int GW = $clog2(GAP + 1);
            logic [GW-1:0] gap_cnt_q, gap_cnt_d;

            // Gap counter runs only while in the gap state and is cleared elsewhere
            always_comb begin
                gap_cnt_d = (state_q == ST_GAP) ? gap_cnt_q + GW'(1) : '0;
            end

            // Gap counter register
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) gap_cnt_q <= '0;
                else       gap_cnt_q <= gap_cnt_d;
            end

            assign gap_last = (gap_cnt_q == GW'(GAP - 1));
        end else begin : g_no_gap
            assign gap_last = 1'b1;
        end
    endgenerate

    // Next-state, serial output and counter decisions
    always_comb begin
        state_d   = state_q;
        xout_d    = 1'b0;
        done_d    = 1'b0;
        hold_d    = hold_q;
        sh_data   = hold_q;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
        rep_cnt_d = rep_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    state_d   = ST_SHIFT;
                    hold_d    = word_i;
                    sh_data   = word_i;
                    sh_load   = 1'b1;
                    xout_d    = sh_tx_bit;
`ifdef SEQ_GEN_REPEAT_EN
                    rep_cnt_d = repeat_i;
`endif
                end
            end
            ST_SHIFT: begin
                if (!sh_last) begin
                    sh_shift = 1'b1;
                    xout_d   = sh_tx_bit;
                end else if (GAP > 0) begin
                    state_d = ST_GAP;
                end else if (reps_left) begin
                    sh_load   = 1'b1;
                    xout_d    = sh_tx_bit;
`ifdef SEQ_GEN_REPEAT_EN
                    rep_cnt_d = rep_cnt_q - RW'(1);
`endif
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_last) begin
                    if (reps_left) begin
                        state_d   = ST_SHIFT;
                        sh_load   = 1'b1;
                        xout_d    = sh_tx_bit;
`ifdef SEQ_GEN_REPEAT_EN
                        rep_cnt_d = rep_cnt_q - RW'(1);
`endif
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and registered outputs; reset drops any partial word without a done pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            xout_q    <= 1'b0;
            done_q    <= 1'b0;
            hold_q    <= '0;
`ifdef SEQ_GEN_REPEAT_EN
            rep_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            xout_q    <= xout_d;
            done_q    <= done_d;
            hold_q    <= hold_d;
`ifdef SEQ_GEN_REPEAT_EN
            rep_cnt_q <= rep_cnt_d;
`endif
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign xout        = xout_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// tb/tb_seq_gen.sv - directed self-checking bench for seq_gen
module tb_seq_gen;

    logic            clk = 1'b0;
    logic            rstn;
    logic [2:0]      sv, sr, xo, bz, dn;
    logic [2:0][3:0] wi;
`ifdef SEQ_GEN_REPEAT_EN
    logic [2:0][3:0] ri;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_gen #(.N(4), .GAP(0)) u_g0 (
        .clk(clk), .rstn(rstn), .start_valid(sv[0]), .start_ready(sr[0]), .word_i(wi[0]),
`ifdef SEQ_GEN_REPEAT_EN
        .repeat_i(ri[0]),
`endif
        .xout(xo[0]), .busy(bz[0]), .done_o(dn[0]));

    seq_gen #(.N(4), .GAP(1)) u_g1 (
        .clk(clk), .rstn(rstn), .start_valid(sv[1]), .start_ready(sr[1]), .word_i(wi[1]),
`ifdef SEQ_GEN_REPEAT_EN
        .repeat_i(ri[1]),
`endif
        .xout(xo[1]), .busy(bz[1]), .done_o(dn[1]));

    seq_gen #(.N(4), .GAP(2)) u_g2 (
        .clk(clk), .rstn(rstn), .start_valid(sv[2]), .start_ready(sr[2]), .word_i(wi[2]),
`ifdef SEQ_GEN_REPEAT_EN
        .repeat_i(ri[2]),
`endif
        .xout(xo[2]), .busy(bz[2]), .done_o(dn[2]));

    // Stand-in for the downstream detector looking for 4'b1011 on the GAP=0 instance
    logic [3:0] det_sh;
    logic       det_o;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) det_sh <= 4'b0;
        else       det_sh <= {det_sh[2:0], xo[0]};
    end
    assign det_o = (det_sh == 4'b1011);

    // Sample after each of len edges, first edge is the accept edge; valid drops after it
    task automatic capture(input int d, input int len,
                           output logic [31:0] xb, output logic [31:0] db,
                           output logic [31:0] bb, output logic [31:0] rb,
                           output logic [31:0] tb);
        xb = '0; db = '0; bb = '0; rb = '0; tb = '0;
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            @(negedge clk);
            xb = {xb[30:0], xo[d]};
            db = {db[30:0], dn[d]};
            bb = {bb[30:0], bz[d]};
            rb = {rb[30:0], sr[d]};
            tb = {tb[30:0], det_o};
            if (i == 0) sv[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        sv   = '0;
        wi   = '0;
`ifdef SEQ_GEN_REPEAT_EN
        ri   = '0;
`endif
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++; if (xo[d] !== 1'b0) begin errors++; $display("FAIL reset_xout[%0d] got=%b exp=0", d, xo[d]); end
            checks++; if (bz[d] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got=%b exp=0", d, bz[d]); end
            checks++; if (sr[d] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d] got=%b exp=1", d, sr[d]); end
            checks++; if (dn[d] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d] got=%b exp=0", d, dn[d]); end
        end
    endtask

    task automatic test_basic();
        logic [31:0] xb, db, bb, rb, tb;
        @(negedge clk);
        checks++; if (sr[0] !== 1'b1) begin errors++; $display("FAIL basic_ready_pre got=%b exp=1", sr[0]); end
        sv[0] = 1'b1;
        wi[0] = 4'b1011;
        capture(0, 6, xb, db, bb, rb, tb);
        checks++; if (xb[5:0] !== 6'b101100) begin errors++; $display("FAIL basic_xout got=%b exp=%b", xb[5:0], 6'b101100); end
        checks++; if (db[5:0] !== 6'b000010) begin errors++; $display("FAIL basic_done got=%b exp=%b", db[5:0], 6'b000010); end
        checks++; if (bb[5:0] !== 6'b111100) begin errors++; $display("FAIL basic_busy got=%b exp=%b", bb[5:0], 6'b111100); end
        checks++; if (rb[5:0] !== 6'b000011) begin errors++; $display("FAIL basic_ready got=%b exp=%b", rb[5:0], 6'b000011); end
        checks++; if (tb[5:0] !== 6'b000010) begin errors++; $display("FAIL basic_det got=%b exp=%b", tb[5:0], 6'b000010); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_gap();
        logic [31:0] xb, db, bb, rb, tb;
        @(negedge clk);
        sv[2] = 1'b1;
        wi[2] = 4'b1100;
        capture(2, 8, xb, db, bb, rb, tb);
        checks++; if (xb[7:0] !== 8'b11000000) begin errors++; $display("FAIL gap_xout got=%b exp=%b", xb[7:0], 8'b11000000); end
        checks++; if (db[7:0] !== 8'b00000010) begin errors++; $display("FAIL gap_done got=%b exp=%b", db[7:0], 8'b00000010); end
        checks++; if (bb[7:0] !== 8'b11111100) begin errors++; $display("FAIL gap_busy got=%b exp=%b", bb[7:0], 8'b11111100); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_repeat();
        logic [31:0] xb, db, bb, rb, tb;
        @(negedge clk);
        sv[1] = 1'b1;
        wi[1] = 4'b1011;
`ifdef SEQ_GEN_REPEAT_EN
        ri[1] = 4'd2;
        capture(1, 17, xb, db, bb, rb, tb);
        ri[1] = 4'd0;
        checks++; if (xb[16:0] !== 17'b10110101101011000) begin errors++; $display("FAIL rep_xout got=%b exp=%b", xb[16:0], 17'b10110101101011000); end
        checks++; if (db[16:0] !== 17'b00000000000000010) begin errors++; $display("FAIL rep_done got=%b exp=%b", db[16:0], 17'b00000000000000010); end
        checks++; if (bb[16:0] !== 17'b11111111111111100) begin errors++; $display("FAIL rep_busy got=%b exp=%b", bb[16:0], 17'b11111111111111100); end
`else
        capture(1, 7, xb, db, bb, rb, tb);
        checks++; if (xb[6:0] !== 7'b1011000) begin errors++; $display("FAIL rep_xout got=%b exp=%b", xb[6:0], 7'b1011000); end
        checks++; if (db[6:0] !== 7'b0000010) begin errors++; $display("FAIL rep_done got=%b exp=%b", db[6:0], 7'b0000010); end
        checks++; if (bb[6:0] !== 7'b1111100) begin errors++; $display("FAIL rep_busy got=%b exp=%b", bb[6:0], 7'b1111100); end
`endif
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] xb, db, bb;
        xb = '0; db = '0; bb = '0;
        @(negedge clk);
        sv[0] = 1'b1;
        wi[0] = 4'b1011;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            xb = {xb[30:0], xo[0]};
            db = {db[30:0], dn[0]};
            bb = {bb[30:0], bz[0]};
            if (i < 4)       wi[0] = 4'b0100 ^ 4'(i);
            else if (i == 4) wi[0] = 4'b0110;
            else if (i == 5) begin sv[0] = 1'b0; wi[0] = 4'b1111; end
        end
        checks++; if (xb[9:0] !== 10'b1011001100) begin errors++; $display("FAIL b2b_xout got=%b exp=%b", xb[9:0], 10'b1011001100); end
        checks++; if (db[9:0] !== 10'b0000100001) begin errors++; $display("FAIL b2b_done got=%b exp=%b", db[9:0], 10'b0000100001); end
        checks++; if (bb[9:0] !== 10'b1111011110) begin errors++; $display("FAIL b2b_busy got=%b exp=%b", bb[9:0], 10'b1111011110); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic [31:0] xb, db, bb, rb, tb;
        logic        any_done;
        @(negedge clk);
        sv[0] = 1'b1;
        wi[0] = 4'b1011;
        @(posedge clk);
        @(negedge clk);
        sv[0] = 1'b0;
        checks++; if (xo[0] !== 1'b1) begin errors++; $display("FAIL mid_bit0 got=%b exp=1", xo[0]); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (xo[0] !== 1'b0) begin errors++; $display("FAIL mid_bit1 got=%b exp=0", xo[0]); end
        rstn = 1'b0;
        #1;
        checks++; if (xo[0] !== 1'b0) begin errors++; $display("FAIL mid_xout got=%b exp=0", xo[0]); end
        checks++; if (bz[0] !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", bz[0]); end
        checks++; if (sr[0] !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", sr[0]); end
        wi[0] = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        any_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            any_done = any_done | dn[0];
        end
        checks++; if (any_done !== 1'b0) begin errors++; $display("FAIL mid_no_done got=%b exp=0", any_done); end
        sv[0] = 1'b1;
        wi[0] = 4'b1011;
        capture(0, 6, xb, db, bb, rb, tb);
        checks++; if (xb[5:0] !== 6'b101100) begin errors++; $display("FAIL mid_resend_xout got=%b exp=%b", xb[5:0], 6'b101100); end
        checks++; if (db[5:0] !== 6'b000010) begin errors++; $display("FAIL mid_resend_done got=%b exp=%b", db[5:0], 6'b000010); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_repeat();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern transmitter: accepts an N-bit word over a valid/ready handshake and drives it MSB-first onto a one-bit serial line, one bit per clock. An optional inter-word gap and an optional repeat count are supported. It sits upstream of the serial pattern detector (`det`). Because it sends MSB-first, the detector's shift register holds the transmitted word exactly N edges after the first bit.

## Interface
- N, 4: word width in bits, N >= 2
- GAP, 0: idle (xout=0) cycles inserted after every word, 0 = none
- RW, 4: width of repeat_i (only with SEQ_GEN_REPEAT_EN)
- clk  in  1  clock
- rstn  in  1  reset: asynchronous, active-low
- start_valid  in  1  request to send word_i
- start_ready  out  1  high only in IDLE (combinational from state)
- word_i  in  N  word to send, sampled on accept
- repeat_i  in  RW  extra repetitions, sampled on accept (SEQ_GEN_REPEAT_EN only)
- xout  out  1  registered serial data
- busy  out  1  state != IDLE
- done_o  out  1  one-cycle pulse when the transfer completes

## Operation
- Accept: start_valid && start_ready at a rising edge.
  - word_i is latched into the shift register; later changes to word_i are ignored.
- States:
  - IDLE: xout=0, start_ready=1. On accept go to SHIFT.
  - SHIFT: xout <= shreg[N-1]; shreg shifts left, bit counter counts 0..N-1. After bit N-1:
    - GAP>0: go to GAP.
    - GAP=0 and reps remain: reload and stay in SHIFT.
    - otherwise: go to IDLE.
  - GAP: xout <= 0 for GAP cycles. Then:
    - reps remain: decrement rep_cnt, reload the latched word, go to SHIFT.
    - otherwise: go to IDLE.
- Word copy: the latched word is kept in a separate hold register so repeats reload it without a handshake.
- Repeat count: rep_cnt loads repeat_i on accept. The word is sent repeat_i+1 times total.
- done_o: registered, asserted for exactly one cycle coincident with entry to IDLE.
- Counter widths:
  - bit_cnt: $clog2(N).
  - gap_cnt: $clog2(GAP+1), or omitted when GAP=0.
  - rep_cnt: RW.
- start_valid while busy: no effect. The request is held by the master until ready.
- Reset mid-transfer: immediate IDLE. xout=0, busy=0, done_o=0; no done pulse is emitted and the partial word is discarded.
- Reset values: xout=0, done_o=0, busy=0, start_ready=1, all counters 0.

## Timing
- Accept at edge k: xout carries word[N-1-i] after edge k+i, for i=0..N-1.
- After edge k+N: gap zeros (GAP cycles), or the next repeat's MSB.
- Single transfer: IDLE re-entered at edge k+N+GAP; done_o high for the cycle after it.
- With R repeats: IDLE at edge k+(R+1)·(N+GAP). Repeats are seamless apart from GAP.
- Earliest next accept: edge k+N+GAP+1. At least one IDLE (xout=0) cycle separates handshake-initiated words.
- Downstream det sees f_shift==word after edge k+N, so det_o is high in the cycle following edge k+N.

## Configuration
- SEQ_GEN_REPEAT_EN
  - Defined: repeat_i port and rep_cnt are present; the behaviour above applies.
  - Undefined: repeat_i and rep_cnt do not exist, and every transfer sends exactly one word then returns to IDLE.
  - Undefined, timing: identical to the repeat_i=0 case.

## Structure
- Shared package seq_pkg:
  - state enum {IDLE, SHIFT, GAP}, encoded in 2 bits.
  - Default N, GAP and RW constants.
- Sub-module seq_gen_shreg:
  - N-bit load/shift register with bit counter and last_bit flag.
  - Instantiated once; FSM and gap/repeat counters stay in seq_gen.

## Test plan
- Reset values:
  - Stimulus: N=4, GAP=0; assert rstn low, release, wait 3 cycles.
  - Response: xout=0, busy=0, start_ready=1, done_o=0.
- Basic transfer:
  - Stimulus: N=4, GAP=0, accept word 4'b1011.
  - Response: xout=1,0,1,1 on edges k..k+3; done_o pulse after edge k+4; start_ready=0 during transfer.
  - Detector: a connected det(PATTERN=4'b1011) shows det_o=1 exactly one cycle.
- Gap insertion:
  - Stimulus: GAP=2, word 4'b1100.
  - Response: xout=1,1,0,0,0,0; IDLE and done_o at edge k+6.
- Repeats (SEQ_GEN_REPEAT_EN):
  - Stimulus: GAP=1, word 4'b1011, repeat_i=2.
  - Response: xout=1011 0 1011 0 1011 0; done_o only once, at edge k+15.
- Busy and handshake:
  - Stimulus: hold start_valid=1 with changing word_i during a transfer.
  - Response: no second accept until start_ready; transmitted bits match the word latched at the first accept.
- Mid-transfer reset:
  - Stimulus: rstn low after 2 bits of 4'b1011.
  - Response: xout=0 immediately, no done_o; a new accept after release sends a full word.
